// File: rtl/lcd_pkg.sv
// Shared definitions for the RGB LCD path: strap codes, panel IDs, the
// per-panel timing table and the bring-up FSM states.
package lcd_pkg;

  localparam int TW = 11;

  localparam logic [2:0] STRAP_480X272   = 3'b000;
  localparam logic [2:0] STRAP_800X480_A = 3'b001;
  localparam logic [2:0] STRAP_1024X600  = 3'b010;
  localparam logic [2:0] STRAP_800X480_B = 3'b100;
  localparam logic [2:0] STRAP_1280X800  = 3'b101;

  localparam logic [15:0] LCD_ID_4342 = 16'h4342;
  localparam logic [15:0] LCD_ID_7084 = 16'h7084;
  localparam logic [15:0] LCD_ID_7016 = 16'h7016;
  localparam logic [15:0] LCD_ID_4384 = 16'h4384;
  localparam logic [15:0] LCD_ID_1018 = 16'h1018;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_SAMPLE,
    ST_LOCK,
    ST_RUN,
    ST_ERR
  } id_state_t;

  typedef logic [1:0] tim_idx_t;

  typedef struct packed {
    logic [2:0]    ratio;
    logic [TW-1:0] h_sync;
    logic [TW-1:0] h_bp;
    logic [TW-1:0] h_act;
    logic [TW-1:0] h_fp;
    logic [TW-1:0] h_tot;
    logic [TW-1:0] v_sync;
    logic [TW-1:0] v_bp;
    logic [TW-1:0] v_act;
    logic [TW-1:0] v_fp;
    logic [TW-1:0] v_tot;
  } timing_t;

  typedef struct packed {
    logic        ok;
    tim_idx_t    idx;
    logic [15:0] id;
  } decode_t;

  function automatic timing_t make_timing(input int ratio,
                                          input int hs, input int hb, input int ha, input int hf,
                                          input int vs, input int vb, input int va, input int vf);
    timing_t t;
    t.ratio  = 3'(ratio);
    t.h_sync = TW'(hs);
    t.h_bp   = TW'(hb);
    t.h_act  = TW'(ha);
    t.h_fp   = TW'(hf);
    t.h_tot  = TW'(hs + hb + ha + hf);
    t.v_sync = TW'(vs);
    t.v_bp   = TW'(vb);
    t.v_act  = TW'(va);
    t.v_fp   = TW'(vf);
    t.v_tot  = TW'(vs + vb + va + vf);
    return t;
  endfunction

  localparam timing_t TIM_480X272  = make_timing(4, 41, 2, 480, 2, 10, 2, 272, 2);
  localparam timing_t TIM_800X480  = make_timing(2, 128, 88, 800, 40, 2, 33, 480, 10);
  localparam timing_t TIM_1024X600 = make_timing(1, 20, 140, 1024, 160, 3, 20, 600, 12);
  localparam timing_t TIM_1280X800 = make_timing(1, 10, 80, 1280, 70, 3, 10, 800, 10);

  function automatic timing_t timing_lookup(input tim_idx_t idx);
    case (idx)
      2'd0:    return TIM_480X272;
      2'd1:    return TIM_800X480;
      2'd2:    return TIM_1024X600;
      default: return TIM_1280X800;
    endcase
  endfunction

  // Both 800x480 strap codes share one timing set but report distinct IDs.
  function automatic decode_t decode_strap(input logic [2:0] code);
    decode_t d;
    d = '0;
    case (code)
      STRAP_480X272:   d = '{ok: 1'b1, idx: 2'd0, id: LCD_ID_4342};
      STRAP_800X480_A: d = '{ok: 1'b1, idx: 2'd1, id: LCD_ID_7084};
      STRAP_1024X600:  d = '{ok: 1'b1, idx: 2'd2, id: LCD_ID_7016};
      STRAP_800X480_B: d = '{ok: 1'b1, idx: 2'd1, id: LCD_ID_4384};
      STRAP_1280X800:  d = '{ok: 1'b1, idx: 2'd3, id: LCD_ID_1018};
      default:         d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [23:0] bar_color(input logic [2:0] bar);
    case (bar)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/lcd_id_detect.sv
// Panel ID bring-up: waits for straps to settle, debounces them, then locks
// the decoded ID (or flags an unsupported code) until the next reset.
module lcd_id_detect
  import lcd_pkg::*;
#(
  parameter int STRAP_SETTLE = 1000,
  parameter int STABLE_CNT   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  id_pins,
  output logic [15:0] lcd_id,
  output logic        id_valid,
  output logic        id_err,
  output tim_idx_t    tim_idx,
  output logic        lock_ok
);

  localparam int SETW = $clog2(STRAP_SETTLE + 1);
  localparam int STW  = $clog2(STABLE_CNT + 1);

  id_state_t   state, state_n;
  logic [SETW-1:0] settle_cnt, settle_n;
  logic [STW-1:0]  stab_cnt, stab_n;
  logic [2:0]  prev, prev_n;
  logic [15:0] id_n;
  logic        valid_n, err_n;
  tim_idx_t    idx_n;
  decode_t     dec;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_WAIT;
      settle_cnt <= '0;
      stab_cnt   <= '0;
      prev       <= '0;
      lcd_id     <= '0;
      id_valid   <= 1'b0;
      id_err     <= 1'b0;
      tim_idx    <= '0;
    end else begin
      state      <= state_n;
      settle_cnt <= settle_n;
      stab_cnt   <= stab_n;
      prev       <= prev_n;
      lcd_id     <= id_n;
      id_valid   <= valid_n;
      id_err     <= err_n;
      tim_idx    <= idx_n;
    end
  end

  // A zero stability count marks the first sample, which always starts a new run.
  always_comb begin
    state_n  = state;
    settle_n = settle_cnt;
    stab_n   = stab_cnt;
    prev_n   = prev;
    id_n     = lcd_id;
    valid_n  = id_valid;
    err_n    = id_err;
    idx_n    = tim_idx;
    lock_ok  = 1'b0;
    dec      = decode_strap(prev);
    case (state)
      ST_WAIT: begin
        if (settle_cnt == SETW'(STRAP_SETTLE - 1)) begin
          state_n = ST_SAMPLE;
          stab_n  = '0;
        end else begin
          settle_n = settle_cnt + SETW'(1);
        end
      end
      ST_SAMPLE: begin
        prev_n = id_pins;
        if (stab_cnt == '0 || id_pins != prev) stab_n = STW'(1);
        else                                    stab_n = stab_cnt + STW'(1);
        if (stab_n == STW'(STABLE_CNT)) state_n = ST_LOCK;
      end
      ST_LOCK: begin
        if (dec.ok) begin
          id_n    = dec.id;
          valid_n = 1'b1;
          idx_n   = dec.idx;
          lock_ok = 1'b1;
          state_n = ST_RUN;
        end else begin
          id_n    = '0;
          err_n   = 1'b1;
          state_n = ST_ERR;
        end
      end
      ST_RUN, ST_ERR: begin
      end
      default: state_n = ST_WAIT;
    endcase
  end

endmodule

// File: rtl/lcd_timing_ctrl.sv
// Panel bring-up plus raster generator (pixel enable, syncs, DE, coordinates).
// Define LCD_TEST_PATTERN_EN to add the 8-bar colour test pattern on test_rgb.
module lcd_timing_ctrl
  import lcd_pkg::*;
#(
  parameter int STRAP_SETTLE = 1000,
  parameter int STABLE_CNT   = 16,
  parameter int CW           = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    id_pins,
  output logic [15:0]   lcd_id,
  output logic          id_valid,
  output logic          id_err,
  output logic          pix_en,
  output logic          lcd_de,
  output logic          lcd_hs,
  output logic          lcd_vs,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          frame_start
`ifdef LCD_TEST_PATTERN_EN
  ,
  output logic [23:0]   test_rgb
`endif
);

  tim_idx_t      tim_idx;
  logic          lock_ok;
  timing_t       tim;
  logic [2:0]    phase, phase_n;
  logic [CW-1:0] h_cnt, v_cnt;
  logic [CW-1:0] h_sync, v_sync, h_start, v_start, h_end, v_end, h_tot, v_tot;
  logic [CW-1:0] x_off, y_off;
  logic          h_last, v_last, de_c;
  logic          unused_fp;

  lcd_id_detect #(
    .STRAP_SETTLE (STRAP_SETTLE),
    .STABLE_CNT   (STABLE_CNT)
  ) u_id_detect (
    .clk      (clk),
    .rst_n    (rst_n),
    .id_pins  (id_pins),
    .lcd_id   (lcd_id),
    .id_valid (id_valid),
    .id_err   (id_err),
    .tim_idx  (tim_idx),
    .lock_ok  (lock_ok)
  );

  assign tim     = timing_lookup(tim_idx);
  assign h_sync  = CW'(tim.h_sync);
  assign v_sync  = CW'(tim.v_sync);
  assign h_start = CW'(tim.h_sync + tim.h_bp);
  assign v_start = CW'(tim.v_sync + tim.v_bp);
  assign h_end   = h_start + CW'(tim.h_act);
  assign v_end   = v_start + CW'(tim.v_act);
  assign h_tot   = CW'(tim.h_tot);
  assign v_tot   = CW'(tim.v_tot);
  // Front porches are already folded into the totals.
  assign unused_fp = ^{tim.h_fp, tim.v_fp};

  assign phase_n = (phase == tim.ratio - 3'd1) ? 3'd0 : phase + 3'd1;
  assign h_last  = (h_cnt == h_tot - CW'(1));
  assign v_last  = (v_cnt == v_tot - CW'(1));
  assign de_c    = (h_cnt >= h_start) && (h_cnt < h_end) &&
                   (v_cnt >= v_start) && (v_cnt < v_end);
  assign x_off   = h_cnt - h_start;
  assign y_off   = v_cnt - v_start;

  // The lock cycle primes the prescaler so the first RUN cycle carries pix_en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase       <= 3'd0;
      pix_en      <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      lcd_de      <= 1'b0;
      lcd_hs      <= 1'b1;
      lcd_vs      <= 1'b1;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else if (lock_ok) begin
      phase  <= 3'd0;
      pix_en <= 1'b1;
    end else if (id_valid) begin
      phase       <= phase_n;
      pix_en      <= (phase_n == 3'd0);
      frame_start <= pix_en && (h_cnt == '0) && (v_cnt == '0);
      if (pix_en) begin
        h_cnt <= h_last ? '0 : h_cnt + CW'(1);
        if (h_last) v_cnt <= v_last ? '0 : v_cnt + CW'(1);
        lcd_hs <= (h_cnt >= h_sync);
        lcd_vs <= (v_cnt >= v_sync);
        lcd_de <= de_c;
        pix_x  <= de_c ? x_off : '0;
        pix_y  <= de_c ? y_off : '0;
      end
    end
  end

`ifdef LCD_TEST_PATTERN_EN
  logic [CW-1:0] bar_w;
  logic [2:0]    bar_idx;

  assign bar_w = CW'(tim.h_act >> 3);

  // Bar index from running multiples of the bar width instead of a divider.
  always_comb begin
    logic [CW-1:0] thr;
    bar_idx = 3'd0;
    thr     = bar_w;
    for (int k = 1; k < 8; k++) begin
      if (x_off >= thr) bar_idx = 3'(k);
      thr = thr + bar_w;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      test_rgb <= '0;
    end else if (id_valid && pix_en) begin
      test_rgb <= de_c ? bar_color(bar_idx) : 24'h000000;
    end
  end
`endif

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Randomised bench for lcd_timing_ctrl: straps, glitches and reset points vary
// per run; every cycle is compared with an arithmetic model of the panel timing.
module tb_lcd_timing_ctrl;

  localparam int STRAP_SETTLE = 1000;
  localparam int STABLE_CNT   = 16;
  localparam int CW           = 11;
  localparam int MAXE         = 8000;

  typedef struct {
    bit          ok;
    logic [15:0] id;
    int          ratio;
    int          hs, hb, ha, hf;
    int          vs, vb, va, vf;
  } panel_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    id_pins = 3'b000;
  logic [15:0]   lcd_id;
  logic          id_valid, id_err, pix_en, lcd_de, lcd_hs, lcd_vs, frame_start;
  logic [CW-1:0] pix_x, pix_y;
`ifdef LCD_TEST_PATTERN_EN
  logic [23:0]   test_rgb;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int straps [MAXE];

  lcd_timing_ctrl #(
    .STRAP_SETTLE (STRAP_SETTLE),
    .STABLE_CNT   (STABLE_CNT),
    .CW           (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_pins     (id_pins),
    .lcd_id      (lcd_id),
    .id_valid    (id_valid),
    .id_err      (id_err),
    .pix_en      (pix_en),
    .lcd_de      (lcd_de),
    .lcd_hs      (lcd_hs),
    .lcd_vs      (lcd_vs),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .frame_start (frame_start)
`ifdef LCD_TEST_PATTERN_EN
    ,
    .test_rgb    (test_rgb)
`endif
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0h, required %0h", tag, observed, expected);
    end
  endtask

  function automatic panel_t panel_for(input int code);
    panel_t p;
    p = '{0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    case (code)
      0: p = '{1, 16'h4342, 4, 41, 2, 480, 2, 10, 2, 272, 2};
      1: p = '{1, 16'h7084, 2, 128, 88, 800, 40, 2, 33, 480, 10};
      2: p = '{1, 16'h7016, 1, 20, 140, 1024, 160, 3, 20, 600, 12};
      4: p = '{1, 16'h4384, 2, 128, 88, 800, 40, 2, 33, 480, 10};
      5: p = '{1, 16'h1018, 1, 10, 80, 1280, 70, 3, 10, 800, 10};
      default: p = '{0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    endcase
    return p;
  endfunction

  function automatic logic [23:0] bar_rgb(input int bar);
    case (bar)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // k counts clocks since the first RUN cycle; pixel p is shown for the ratio
  // clocks that follow its pix_en, so outputs lag the pixel clock by one clk.
  function automatic logic [63:0] exp_pixel(input panel_t p, input int k);
    int pix, h, v, ht, vt, x, y;
    bit pe, de, hs, vs, fs;
    logic [23:0] rgb;
    logic [10:0] xv, yv;
    pe = 0; de = 0; hs = 1; vs = 1; fs = 0; x = 0; y = 0; rgb = 24'h0;
    if (p.ok && k >= 0) begin
      ht = p.hs + p.hb + p.ha + p.hf;
      vt = p.vs + p.vb + p.va + p.vf;
      pe = ((k % p.ratio) == 0);
      if (k >= 1) begin
        pix = (k - 1) / p.ratio;
        h = pix % ht;
        v = (pix / ht) % vt;
        hs = (h >= p.hs);
        vs = (v >= p.vs);
        de = (h >= p.hs + p.hb) && (h < p.hs + p.hb + p.ha) &&
             (v >= p.vs + p.vb) && (v < p.vs + p.vb + p.va);
        fs = (((k - 1) % (p.ratio * ht * vt)) == 0);
        if (de) begin
          x = h - (p.hs + p.hb);
          y = v - (p.vs + p.vb);
          rgb = bar_rgb(x * 8 / p.ha);
        end
      end
    end
    xv = 11'(x);
    yv = 11'(y);
    return {13'd0, rgb, pe, de, hs, vs, fs, xv, yv};
  endfunction

  task automatic applyStimulus(input int code, input int glitch_len, input int run_cycles, input bit change_after_lock);
    panel_t      p;
    int          total, lock_edge, run, k;
    logic [63:0] exp;
    logic [17:0] exp_id;
    p = panel_for(code);
    total = STRAP_SETTLE + glitch_len + STABLE_CNT + 2 + run_cycles;
    for (int e = 0; e < total; e++) begin
      if (e < STRAP_SETTLE)                   straps[e] = int'($urandom_range(0, 7));
      else if (e < STRAP_SETTLE + glitch_len) straps[e] = ((((e - STRAP_SETTLE) / 5) % 2) == 1) ? (code ^ 1) : code;
      else                                    straps[e] = code;
    end
    lock_edge = -1;
    run = 0;
    for (int e = STRAP_SETTLE; e < total && lock_edge < 0; e++) begin
      run = (e == STRAP_SETTLE || straps[e] != straps[e-1]) ? 1 : run + 1;
      if (run == STABLE_CNT) lock_edge = e;
    end
    if (change_after_lock && lock_edge >= 0)
      for (int e = lock_edge + 1; e < total; e++) straps[e] = int'($urandom_range(0, 7));

    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput($sformatf("reset_id c%0d", code), {46'd0, lcd_id, id_valid, id_err}, 64'd0);
    exp = exp_pixel(p, -1);
    checkOutput($sformatf("reset_raster c%0d", code),
                {37'd0, pix_en, lcd_de, lcd_hs, lcd_vs, frame_start, pix_x, pix_y}, {37'd0, exp[26:0]});
    rst_n = 1'b1;

    for (int e = 0; e < total; e++) begin
      id_pins = 3'(straps[e]);
      @(posedge clk);
      @(negedge clk);
      k = (lock_edge < 0) ? -1 : (e + 1) - (lock_edge + 2);
      if (k < 0)     exp_id = 18'd0;
      else if (p.ok) exp_id = {p.id, 2'b10};
      else           exp_id = {16'h0000, 2'b01};
      checkOutput($sformatf("id c%0d @%0d", code, e + 1), {46'd0, lcd_id, id_valid, id_err}, {46'd0, exp_id});
      exp = exp_pixel(p, k);
      checkOutput($sformatf("raster c%0d @%0d", code, e + 1),
                  {37'd0, pix_en, lcd_de, lcd_hs, lcd_vs, frame_start, pix_x, pix_y}, {37'd0, exp[26:0]});
`ifdef LCD_TEST_PATTERN_EN
      checkOutput($sformatf("rgb c%0d @%0d", code, e + 1), {40'd0, test_rgb}, {40'd0, exp[50:27]});
`endif
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    // Two full lines each for the 800x480 and 480x272 panels.
    applyStimulus(1, 0, 4250, 1'b0);
    applyStimulus(0, 0, 4220, 1'b0);
    applyStimulus(2, int'($urandom_range(40, 100)), 2720, 1'b0);
    applyStimulus(7, int'($urandom_range(0, 30)), 400, 1'b1);
    // The second 1280x800 run opens with a one-cycle reset mid-frame of the first.
    applyStimulus(5, 0, int'($urandom_range(300, 2000)), 1'b0);
    applyStimulus(5, 0, 1500, 1'b0);
    repeat (2) applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 60)), 1500, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
